// File: rtl/fir_pkg.sv
// Shared state encoding and default sizing for the FIR input sequencer.
// FIR_SEQ_CTRL_DRAIN_EN adds the DRAIN state that flushes the FIR tail.
package fir_pkg;

    localparam int DEF_NBR_OF_TAPS  = 3;
    localparam int DEF_TAP_SIZE     = 3;
    localparam int DEF_X_N_SIZE     = 8;
    localparam int DEF_SETUP_CYCLES = 4;

    typedef enum logic [2:0] {
        ST_SETUP  = 3'd0,
        ST_IDLE   = 3'd1,
        ST_LOAD   = 3'd2,
        ST_STREAM = 3'd3
`ifdef FIR_SEQ_CTRL_DRAIN_EN
        , ST_DRAIN = 3'd4
`endif
    } fir_state_e;

endpackage

// File: rtl/fir_coef_shifter.sv
// Holds a captured coefficient set and walks its taps from the top slice down,
// presenting the sign-extended slice that will be on the bus next cycle.
module fir_coef_shifter
    import fir_pkg::*;
#(
    parameter int NBR_OF_TAPS = DEF_NBR_OF_TAPS,
    parameter int TAP_SIZE    = DEF_TAP_SIZE,
    parameter int X_N_SIZE    = DEF_X_N_SIZE
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            load_i,
    input  logic                            shift_i,
    input  logic [NBR_OF_TAPS*TAP_SIZE-1:0] coef_data_i,
    output logic [X_N_SIZE-1:0]             slice_o,
    output logic                            last_o
);
    localparam int IDX_W = (NBR_OF_TAPS > 1) ? $clog2(NBR_OF_TAPS) : 1;

    logic [NBR_OF_TAPS-1:0][TAP_SIZE-1:0] hold_q, hold_d;
    logic [IDX_W-1:0]                     idx_q, idx_d;
    logic signed [TAP_SIZE-1:0]           tap;
    logic signed [X_N_SIZE-1:0]           tap_ext;

    always_comb begin
        hold_d = hold_q;
        idx_d  = idx_q;
        if (load_i) begin
            hold_d = coef_data_i;
            idx_d  = IDX_W'(NBR_OF_TAPS - 1);
        end else if (shift_i && idx_q != '0) begin
            idx_d = idx_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hold_q <= '0;
            idx_q  <= '0;
        end else begin
            hold_q <= hold_d;
            idx_q  <= idx_d;
        end
    end

    // Look ahead through the next-state values so the top can register the slice.
    assign tap     = hold_d[idx_d];
    assign tap_ext = X_N_SIZE'(tap);
    assign slice_o = tap_ext;
    assign last_o  = (idx_q == '0);

endmodule

// File: rtl/fir_seq_ctrl.sv
// Sequencer feeding a FIR: coefficient loads, sample streaming, optional tail
// flush (DRAIN, enabled by FIR_SEQ_CTRL_DRAIN_EN). FIR-side outputs are registered.
module fir_seq_ctrl
    import fir_pkg::*;
#(
    parameter int NBR_OF_TAPS  = DEF_NBR_OF_TAPS,
    parameter int TAP_SIZE     = DEF_TAP_SIZE,
    parameter int X_N_SIZE     = DEF_X_N_SIZE,
    parameter int SETUP_CYCLES = DEF_SETUP_CYCLES
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            coef_valid,
    input  logic [NBR_OF_TAPS*TAP_SIZE-1:0] coef_data,
    output logic                            coef_ready,
    input  logic                            smp_valid,
    input  logic [X_N_SIZE-1:0]             smp_data,
    output logic                            smp_ready,
    output logic [X_N_SIZE-1:0]             fir_x_n,
    output logic                            fir_tvalid,
    output logic                            fir_set_coeffs,
    output logic                            cfg_done,
    output logic                            busy
);
    localparam int SU_W = (SETUP_CYCLES > 1) ? $clog2(SETUP_CYCLES) : 1;

    fir_state_e          state_q, state_d;
    logic [SU_W-1:0]     setup_q, setup_d;
    logic [X_N_SIZE-1:0] x_n_q, x_n_d;
    logic                tvalid_q, tvalid_d;
    logic                setc_q, setc_d;
    logic                done_q, done_d;
    logic                busy_q, busy_d;
    logic                coef_acc, smp_acc, setup_done;
    logic                coef_last;
    logic [X_N_SIZE-1:0] coef_slice;

`ifdef FIR_SEQ_CTRL_DRAIN_EN
    localparam int DRN_W = $clog2(2 * NBR_OF_TAPS);
    logic [DRN_W-1:0] drn_q, drn_d;
`endif

    // Readies are decoded from registered state so they can react to valid in-cycle.
    assign coef_acc   = (state_q == ST_IDLE) && coef_valid;
    assign smp_acc    = (state_q == ST_STREAM) && smp_valid && !coef_valid;
    assign setup_done = (int'(setup_q) >= SETUP_CYCLES - 1);

    fir_coef_shifter #(
        .NBR_OF_TAPS (NBR_OF_TAPS),
        .TAP_SIZE    (TAP_SIZE),
        .X_N_SIZE    (X_N_SIZE)
    ) u_shifter (
        .clk         (clk),
        .reset       (reset),
        .load_i      (coef_acc),
        .shift_i     ((state_q == ST_LOAD) && !coef_last),
        .coef_data_i (coef_data),
        .slice_o     (coef_slice),
        .last_o      (coef_last)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_SETUP;
            setup_q  <= '0;
            x_n_q    <= '0;
            tvalid_q <= 1'b0;
            setc_q   <= 1'b0;
            done_q   <= 1'b0;
            busy_q   <= 1'b1;
        end else begin
            state_q  <= state_d;
            setup_q  <= setup_d;
            x_n_q    <= x_n_d;
            tvalid_q <= tvalid_d;
            setc_q   <= setc_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
        end
    end

`ifdef FIR_SEQ_CTRL_DRAIN_EN
    always_ff @(posedge clk) begin
        if (reset) drn_q <= '0;
        else       drn_q <= drn_d;
    end
`endif

    always_comb begin
        state_d = state_q;
        setup_d = setup_q;
`ifdef FIR_SEQ_CTRL_DRAIN_EN
        drn_d   = drn_q;
`endif
        case (state_q)
            ST_SETUP: begin
                if (setup_done) state_d = ST_IDLE;
                else            setup_d = setup_q + 1'b1;
            end
            ST_IDLE: begin
                if (coef_valid)     state_d = ST_LOAD;
                else if (smp_valid) state_d = ST_STREAM;
            end
            ST_LOAD: begin
                if (coef_last) state_d = ST_IDLE;
            end
            ST_STREAM: begin
                // Any cycle without an accepted sample ends the burst.
                if (!smp_acc) begin
`ifdef FIR_SEQ_CTRL_DRAIN_EN
                    state_d = ST_DRAIN;
                    drn_d   = DRN_W'(2 * NBR_OF_TAPS - 2);
`else
                    state_d = ST_IDLE;
`endif
                end
            end
`ifdef FIR_SEQ_CTRL_DRAIN_EN
            ST_DRAIN: begin
                if (drn_q == '0) state_d = ST_IDLE;
                else             drn_d   = drn_q - 1'b1;
            end
`endif
            default: state_d = ST_SETUP;
        endcase
    end

    always_comb begin
        x_n_d    = '0;
        tvalid_d = 1'b0;
        setc_d   = 1'b0;
        done_d   = (state_q == ST_LOAD) && coef_last;
        busy_d   = (state_d != ST_IDLE);
        if (smp_acc) begin
            x_n_d    = smp_data;
            tvalid_d = 1'b1;
        end
        case (state_d)
            ST_LOAD: begin
                setc_d = 1'b1;
                x_n_d  = coef_slice;
            end
`ifdef FIR_SEQ_CTRL_DRAIN_EN
            ST_DRAIN: tvalid_d = 1'b1;
`endif
            default: ;
        endcase
    end

    assign coef_ready     = coef_acc;
    assign smp_ready      = smp_acc;
    assign fir_x_n        = x_n_q;
    assign fir_tvalid     = tvalid_q;
    assign fir_set_coeffs = setc_q;
    assign cfg_done       = done_q;
    assign busy           = busy_q;

endmodule
